chacha_block_ctrl: RTL and testbench



---
 rtl/chacha_pkg.sv | 38 +++
 rtl/chacha_qr.sv | 38 +++
 rtl/chacha_block_ctrl.sv | 149 ++++++++++++++
 tb/tb_chacha_block_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// ---------------------------------------------------------------------------
// chacha_pkg
// Shared types and constants for the iterative ChaCha block controller.
//   chacha_word_t  : one 32-bit state word
//   chacha_state_t : 16 packed words, word i at bits [32*i +: 32]
//   chacha_fsm_e   : controller states (IDLE, RUN, DONE)
//   QR_IDX         : (a,b,c,d) word indices for the 8 quarter-round slots
//                    of one double round (4 columns, then 4 diagonals)
//   CHACHA_CONST0..3 : "expand 32-byte k" constant words
// ---------------------------------------------------------------------------
package chacha_pkg;

    typedef logic [31:0] chacha_word_t;
    typedef chacha_word_t [15:0] chacha_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chacha_fsm_e;

    localparam logic [3:0] QR_IDX [8][4] = '{
        '{4'd0, 4'd4, 4'd8,  4'd12},
        '{4'd1, 4'd5, 4'd9,  4'd13},
        '{4'd2, 4'd6, 4'd10, 4'd14},
        '{4'd3, 4'd7, 4'd11, 4'd15},
        '{4'd0, 4'd5, 4'd10, 4'd15},
        '{4'd1, 4'd6, 4'd11, 4'd12},
        '{4'd2, 4'd7, 4'd8,  4'd13},
        '{4'd3, 4'd4, 4'd9,  4'd14}
    };

    localparam chacha_word_t CHACHA_CONST0 = 32'h61707865;
    localparam chacha_word_t CHACHA_CONST1 = 32'h3320646e;
    localparam chacha_word_t CHACHA_CONST2 = 32'h79622d32;
    localparam chacha_word_t CHACHA_CONST3 = 32'h6b206574;

endpackage

// File: rtl/chacha_qr.sv
// ---------------------------------------------------------------------------
// chacha_qr
// Combinational ChaCha quarter-round. All additions are mod 2^32.
//   a_i..d_i : input words
//   a_o..d_o : output words
// ---------------------------------------------------------------------------
module chacha_qr
    import chacha_pkg::*;
(
    input  chacha_word_t a_i,
    input  chacha_word_t b_i,
    input  chacha_word_t c_i,
    input  chacha_word_t d_i,
    output chacha_word_t a_o,
    output chacha_word_t b_o,
    output chacha_word_t c_o,
    output chacha_word_t d_o
);

    function automatic chacha_word_t rotl(input chacha_word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    chacha_word_t a1, b1, c1, d1;

    // First half: rotations 16 and 12.
    assign a1 = a_i + b_i;
    assign d1 = rotl(d_i ^ a1, 16);
    assign c1 = c_i + d1;
    assign b1 = rotl(b_i ^ c1, 12);

    // Second half: rotations 8 and 7.
    assign a_o = a1 + b1;
    assign d_o = rotl(d1 ^ a_o, 8);
    assign c_o = c1 + d_o;
    assign b_o = rotl(b1 ^ c_o, 7);

endmodule

// File: rtl/chacha_block_ctrl.sv
// ---------------------------------------------------------------------------
// chacha_block_ctrl
// Iterative ChaCha block function: one quarter-round per clock through a
// single chacha_qr, alternating column and diagonal rounds, result offered
// on a valid/ready handshake.
//
// Parameter:
//   ROUNDS     : number of ChaCha rounds (even, >= 2; 8/12/20 typical)
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high
//   in_valid   : init_state valid
//   in_ready   : controller can take a new state
//   init_state : input state, word i at [32*i +: 32]
//   out_valid  : out_state valid
//   out_ready  : downstream takes out_state
//   out_state  : result, same packing as init_state
//   busy       : rounds in progress
//
// Build option:
//   CHACHA_FEEDFORWARD_EN defined   -> out_state = work + orig (full block
//                                      function); orig register present.
//   CHACHA_FEEDFORWARD_EN undefined -> out_state = work (raw permutation).
// ---------------------------------------------------------------------------
module chacha_block_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] init_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_state,
    output logic         busy
);

    localparam int QR_TOTAL = ROUNDS * 4;
    localparam int QR_CNT_W = $clog2(QR_TOTAL);
    localparam logic [QR_CNT_W-1:0] QR_LAST = QR_CNT_W'(QR_TOTAL - 1);

    chacha_fsm_e          state_q, state_d;
    chacha_state_t        work_q, work_d;
    logic [QR_CNT_W-1:0]  qr_cnt_q, qr_cnt_d;
`ifdef CHACHA_FEEDFORWARD_EN
    chacha_state_t        orig_q, orig_d;
`endif

    logic         accept;
    logic [3:0]   idx_a, idx_b, idx_c, idx_d;
    chacha_word_t qa_o, qb_o, qc_o, qd_o;

    // Low three counter bits walk the 8 slots of a double round.
    assign idx_a = QR_IDX[qr_cnt_q[2:0]][0];
    assign idx_b = QR_IDX[qr_cnt_q[2:0]][1];
    assign idx_c = QR_IDX[qr_cnt_q[2:0]][2];
    assign idx_d = QR_IDX[qr_cnt_q[2:0]][3];

    chacha_qr u_qr (
        .a_i (work_q[idx_a]),
        .b_i (work_q[idx_b]),
        .c_i (work_q[idx_c]),
        .d_i (work_q[idx_d]),
        .a_o (qa_o),
        .b_o (qb_o),
        .c_o (qc_o),
        .d_o (qd_o)
    );

    // Ready in DONE only when the current result leaves this same cycle,
    // which lets a new block load back-to-back.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        qr_cnt_d = qr_cnt_q;
`ifdef CHACHA_FEEDFORWARD_EN
        orig_d   = orig_q;
`endif
        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                // The four indices of one slot are distinct, so the
                // writebacks never collide.
                work_d[idx_a] = qa_o;
                work_d[idx_b] = qb_o;
                work_d[idx_c] = qc_o;
                work_d[idx_d] = qd_o;
                if (qr_cnt_q == QR_LAST) begin
                    qr_cnt_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    qr_cnt_d = qr_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // accept is never true in RUN, so this cannot clobber a writeback.
        if (accept) begin
            work_d   = init_state;
`ifdef CHACHA_FEEDFORWARD_EN
            orig_d   = init_state;
`endif
            qr_cnt_d = '0;
            state_d  = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            qr_cnt_q <= '0;
`ifdef CHACHA_FEEDFORWARD_EN
            orig_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            qr_cnt_q <= qr_cnt_d;
`ifdef CHACHA_FEEDFORWARD_EN
            orig_q   <= orig_d;
`endif
        end
    end

`ifdef CHACHA_FEEDFORWARD_EN
    always_comb begin
        out_state = '0;
        for (int i = 0; i < 16; i++) begin
            out_state[32*i +: 32] = work_q[i] + orig_q[i];
        end
    end
`else
    assign out_state = work_q;
`endif

endmodule

// File: tb/tb_chacha_block_ctrl.sv
module tb_chacha_block_ctrl;

    localparam int ROUNDS = 20;
    localparam int NQR    = ROUNDS * 4;
`ifdef CHACHA_FEEDFORWARD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [511:0] init_state = '0;
    logic         in_ready, out_valid, busy;
    logic [511:0] out_state;

    chacha_block_ctrl #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .init_state (init_state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference ChaCha block function ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] ref_block(input logic [511:0] s, input bit ff);
        logic [31:0]  x [16];
        logic [127:0] t;
        logic [511:0] r;
        int ia, ib, ic, id;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int dr = 0; dr < ROUNDS / 2; dr++) begin
            for (int k = 0; k < 8; k++) begin
                ia = k % 4;
                if (k < 4) begin
                    ib = ia + 4; ic = ia + 8; id = ia + 12;
                end else begin
                    ib = 4 + (ia + 1) % 4; ic = 8 + (ia + 2) % 4; id = 12 + (ia + 3) % 4;
                end
                t = qr(x[ia], x[ib], x[ic], x[id]);
                x[ia] = t[31:0]; x[ib] = t[63:32]; x[ic] = t[95:64]; x[id] = t[127:96];
            end
        end
        for (int i = 0; i < 16; i++)
            r[32*i +: 32] = ff ? x[i] + s[32*i +: 32] : x[i];
        return r;
    endfunction

    function automatic logic [511:0] rfc_vec();
        logic [31:0] w [16];
        logic [511:0] r;
        w = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
              32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
              32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
              32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- transaction-level model ----------------
    // m_left: cycles of rounds still to go; m_done: result on offer;
    // m_show: value out_state must show whenever no rounds are running.
    int           m_left = 0;
    bit           m_done = 1'b0;
    bit           m_start;
    logic [511:0] m_exp  = '0;
    logic [511:0] m_show = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_done = 1'b0; m_exp = '0; m_show = '0;
        end else begin
            m_start = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_show = m_exp;
                end
            end else if (m_done) begin
                if (out_ready) begin
                    m_done  = 1'b0;
                    m_start = in_valid;
                end
            end else begin
                m_start = in_valid;
            end
            if (m_start) begin
                m_exp  = ref_block(init_state, FF);
                m_left = NQR;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en  = 1'b0;
    bit ov_prev = 1'b0;
    int rise_last = 0;
    int rise_prev = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_left != 0);
            chk("out_valid", out_valid, m_done);
            chk("in_ready", in_ready, (m_left == 0) && (!m_done || out_ready));
            if (m_left == 0) chk("out_state", out_state, m_show);
            if (out_valid && !ov_prev) begin
                rise_prev = rise_last;
                rise_last = cyc;
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [511:0] s, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = -1;
        in_valid = 1'b1;
        init_state = s;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("send_accepted", got, 1'b1);
        if (got) acc_cyc = cyc;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        chk("out_valid_seen", ok, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] rfc, mref, held, tmp;
        logic [31:0]  exp_w0, exp_w1;
        int a0, a1, a2;
        bit ok, acc;

        rfc = rfc_vec();
        exp_w0 = FF ? 32'he4e7f110 : 32'h837778ab;
        exp_w1 = FF ? 32'h15593bd1 : 32'he238d763;

        // Pin the reference model to known RFC 7539 numbers.
        mref = ref_block(rfc, 1'b1);
        chk("model_ff_w0", mref[31:0], 32'he4e7f110);
        chk("model_ff_w1", mref[63:32], 32'h15593bd1);
        mref = ref_block(rfc, 1'b0);
        chk("model_raw_w0", mref[31:0], 32'h837778ab);
        chk("model_raw_w1", mref[63:32], 32'he238d763);
        mref = ref_block('0, FF);
        chk("model_zero", mref, '0);

        // Reset state
        repeat (3) step();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_state", out_state, '0);
        step();
        reset = 1'b0;
        step();

        // RFC vector with latency and 10-cycle backpressure
        out_ready = 1'b0;
        send(rfc, a0);
        wait_valid(ok);
        chk("latency", cyc - a0, NQR);
        chk("rfc_w0", out_state[31:0], exp_w0);
        chk("rfc_w1", out_state[63:32], exp_w1);
        held = out_state;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_state", out_state, held);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1'b1);
        step();
        @(negedge clk);
        chk("back_idle_valid", out_valid, 1'b0);
        chk("back_idle_busy", busy, 1'b0);
        step();

        // All-zero state is a fixed point
        send('0, a0);
        wait_valid(ok);
        chk("zero_out", out_state, '0);
        step();
        step();

        // Back-to-back blocks
        out_ready = 1'b1;
        send(rand_state(), a1);
        send(rand_state(), a2);
        chk("b2b_accept_gap", a2 - a1, NQR + 1);
        wait_valid(ok);
        step();
        chk("b2b_valid_gap", rise_last - rise_prev, NQR + 1);
        repeat (2) step();

        // Reset in the middle of a run, then reapply the vector
        send(rfc, a0);
        repeat (40) step();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_out_state", out_state, '0);
        chk("midrst_in_ready", in_ready, 1'b1);
        step();
        reset = 1'b0;
        step();
        send(rfc, a0);
        wait_valid(ok);
        chk("rerun_w0", out_state[31:0], exp_w0);
        chk("rerun_w1", out_state[63:32], exp_w1);
        step();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom % 3) != 0;
            if (!in_valid && ($urandom % 3) == 0) begin
                tmp = rand_state();
                init_state = tmp;
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        repeat (200) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
